// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - tile sequencer for an N x N systolic array
// Walks one tile through clear, skewed operand feed, flush and row drain.
module systolic_seq_ctrl #(
  parameter int N     = 4,
  parameter int K_W   = 8,
  parameter int ROW_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [K_W-1:0]     cfg_k_i,
  input  logic               stall_i,
  input  logic               drain_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               clear_o,
  output logic               pe_en_o,
  output logic [N-1:0]       feed_en_o,
  output logic [N*K_W-1:0]   feed_idx_o,
  output logic               drain_en_o,
  output logic [ROW_W-1:0]   drain_row_o
);

  localparam int T_W = K_W + 1;
  localparam int F_W = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [F_W-1:0]   fl_q, fl_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      fl_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    fl_d        = fl_q;
    row_d       = row_q;
    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;
    clear_o     = 1'b0;
    pe_en_o     = 1'b0;
    feed_en_o   = '0;
    feed_idx_o  = '0;
    drain_en_o  = 1'b0;
    drain_row_o = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          k_d     = cfg_k_i;
          t_d     = '0;
          fl_d    = '0;
          row_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_o = 1'b1;
        state_d = (k_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        pe_en_o = !stall_i;
        if (!stall_i) begin
          // Last phase is K+N-2: lane N-1 injects its final k-index there.
          if (t_q == T_W'(k_q) + T_W'(N - 2)) begin
            t_d     = '0;
            state_d = FLUSH;
          end else begin
            t_d = t_q + 1'b1;
          end
          for (int r = 0; r < N; r++) begin
            if (int'(t_q) >= r && int'(t_q) < r + int'(k_q)) begin
              feed_en_o[r]               = 1'b1;
              feed_idx_o[r*K_W +: K_W]   = K_W'(t_q - T_W'(r));
            end
          end
        end
      end
      FLUSH: begin
        pe_en_o = !stall_i;
        if (!stall_i) begin
          if (fl_q == F_W'(N - 1)) begin
            fl_d    = '0;
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            fl_d = fl_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drain_en_o  = 1'b1;
        drain_row_o = row_q;
        pe_en_o     = drain_ready_i;
        if (drain_ready_i) begin
          if (row_q == ROW_W'(N - 1)) state_d = DONE;
          else                        row_d   = row_q + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
